// File: rtl/sgray_pkg.sv
// Shared helpers for the Gray-pointer FIFO blocks: Gray/binary conversion,
// a multi-bit-change test and default sizing constants.
package sgray_pkg;

  localparam int SGRAY_LEN_DEFAULT = 8;
  localparam int SGRAY_SYNC_MIN    = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit i of the binary value is the parity of Gray bits i and above.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  function automatic logic multi_bit(input logic [31:0] x);
    return (x & (x - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/sgray_rdptr_sync_if.sv
// Read-side FIFO pointer bus: writer Gray pointer in, consumer handshake,
// RAM address, returned Gray read pointer and status flags.
interface sgray_rdptr_sync_if #(
  parameter int LEN = 8
);
  logic [LEN-1:0] wr_gray;
  logic           rd_en;
  logic           rd_ack;
  logic [LEN-2:0] rd_addr;
  logic [LEN-1:0] rd_gray;
  logic           empty;
  logic [LEN-1:0] level;
  logic           err;

  modport master (
    output wr_gray, rd_en,
    input  rd_ack, rd_addr, rd_gray, empty, level, err
  );

  modport slave (
    input  wr_gray, rd_en,
    output rd_ack, rd_addr, rd_gray, empty, level, err
  );
endinterface

// File: rtl/sgray_sync.sv
// LEN-wide multi-flop synchronizer for a Gray pointer crossing clock domains.
// No logic precedes the first stage; all stages reset to zero.
module sgray_sync
  import sgray_pkg::*;
#(
  parameter int LEN         = SGRAY_LEN_DEFAULT,
  parameter int SYNC_STAGES = SGRAY_SYNC_MIN
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic [LEN-1:0] d,
  output logic [LEN-1:0] q
);

  logic [LEN-1:0] stage_d [SYNC_STAGES];
  logic [LEN-1:0] stage_q [SYNC_STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/sgray_rdptr_sync.sv
// Read-domain pointer logic for a dual-clock FIFO: syncs and decodes the writer's
// Gray pointer, keeps the read pointer, flags. Optional checker: SGRAY_CHECK_EN.
module sgray_rdptr_sync
  import sgray_pkg::*;
#(
  parameter int LEN         = SGRAY_LEN_DEFAULT,
  parameter int SYNC_STAGES = SGRAY_SYNC_MIN
) (
  input  logic             CLK,
  input  logic             RST_N,
  sgray_rdptr_sync_if.slave bus
);

  localparam logic [LEN-1:0] DEPTH = {1'b1, {(LEN-1){1'b0}}};

  logic [LEN-1:0] wr_gs;
  logic [LEN-1:0] wr_bin_d, wr_bin_q;
  logic [LEN-1:0] rd_ptr_d, rd_ptr_q;
  logic [LEN-1:0] rd_gray_d, rd_gray_q;
  logic [LEN-1:0] level;
  logic           empty;
  logic           rd_ack;

  sgray_sync #(
    .LEN         (LEN),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (bus.wr_gray),
    .q     (wr_gs)
  );

  // Flags come only from registers, so rd_ack has no path from the async input.
  always_comb begin
    wr_bin_d  = LEN'(gray2bin(32'(wr_gs)));
    empty     = (wr_bin_q == rd_ptr_q);
    level     = wr_bin_q - rd_ptr_q;
    rd_ack    = bus.rd_en & ~empty;
    rd_ptr_d  = rd_ptr_q + LEN'(rd_ack);
    rd_gray_d = LEN'(bin2gray(32'(rd_ptr_d)));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_bin_q  <= '0;
      rd_ptr_q  <= '0;
      rd_gray_q <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_gray_q <= rd_gray_d;
    end
  end

  assign bus.rd_ack  = rd_ack;
  assign bus.rd_addr = rd_ptr_q[LEN-2:0];
  assign bus.rd_gray = rd_gray_q;
  assign bus.empty   = empty;
  assign bus.level   = level;

`ifdef SGRAY_CHECK_EN
  logic [LEN-1:0] prev_gs_q;
  logic           err_d, err_q;

  // A legal Gray stream moves at most one bit per sample; level above depth is overrun.
  always_comb begin
    err_d = err_q | multi_bit(32'(wr_gs ^ prev_gs_q)) | (level > DEPTH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      prev_gs_q <= '0;
      err_q     <= 1'b0;
    end else begin
      prev_gs_q <= wr_gs;
      err_q     <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_sgray_rdptr_sync.sv
// Scoreboard bench for sgray_rdptr_sync at LEN=4, SYNC_STAGES=2; expected
// write-pointer values are queued when driven and popped when they surface.
module tb_sgray_rdptr_sync;

  localparam int LEN   = 4;
  localparam int SYNC  = 2;
  localparam int MASK  = 15;
  localparam int DEPTH = 8;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  sgray_rdptr_sync_if #(.LEN(LEN)) bus ();

  sgray_rdptr_sync #(
    .LEN         (LEN),
    .SYNC_STAGES (SYNC)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int bin_q[$];
  int gs_q[$];
  int m_rd, m_rdgray, m_gsprev, w;
  bit m_err;

  function automatic int tb_gray(input int x);
    return (x ^ (x >> 1)) & MASK;
  endfunction

  function automatic int tb_bin(input int g);
    int b;
    b = 0;
    for (int s = g; s != 0; s = s >> 1) b = b ^ s;
    return b & MASK;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bin_q = {};
    gs_q  = {};
    for (int i = 0; i < SYNC + 1; i++) bin_q.push_back(0);
    for (int i = 0; i < SYNC; i++) gs_q.push_back(0);
    m_rd     = 0;
    m_rdgray = 0;
    m_gsprev = 0;
    m_err    = 1'b0;
    w        = 0;
  endtask

  // One cycle: drive at negedge, compare the pre-edge state, then advance the model.
  task automatic step(input int wg, input bit ren);
    int m_wr, gs, lvl;
    bit emp, ack;
    @(negedge CLK);
    bus.wr_gray = wg[LEN-1:0];
    bus.rd_en   = ren;
    #1;
    m_wr = bin_q.pop_front();
    gs   = gs_q.pop_front();
    lvl  = (m_wr - m_rd) & MASK;
    emp  = (lvl == 0);
    ack  = ren && !emp;
    check("empty",   int'(bus.empty),   int'(emp));
    check("level",   int'(bus.level),   lvl);
    check("rd_ack",  int'(bus.rd_ack),  int'(ack));
    check("rd_addr", int'(bus.rd_addr), m_rd & 7);
    check("rd_gray", int'(bus.rd_gray), m_rdgray);
`ifdef SGRAY_CHECK_EN
    check("err", int'(bus.err), int'(m_err));
`else
    check("err", int'(bus.err), 0);
`endif
    bin_q.push_back(tb_bin(wg));
    gs_q.push_back(wg);
    if ($countones(gs ^ m_gsprev) > 1 || lvl > DEPTH) m_err = 1'b1;
    m_gsprev = gs;
    if (ack) begin
      m_rd     = (m_rd + 1) & MASK;
      m_rdgray = tb_gray(m_rd);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N       = 1'b0;
    bus.wr_gray = '0;
    bus.rd_en   = 1'b1;
    #2;
    check("rst_empty",   int'(bus.empty),   1);
    check("rst_level",   int'(bus.level),   0);
    check("rst_rd_gray", int'(bus.rd_gray), 0);
    check("rst_rd_ack",  int'(bus.rd_ack),  0);
    check("rst_rd_addr", int'(bus.rd_addr), 0);
    check("rst_err",     int'(bus.err),     0);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    int written;
    bit ren;
    bus.wr_gray = '0;
    bus.rd_en   = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    do_reset();

    // fill 0->1->3->2
    for (int k = 1; k <= 3; k++) begin
      w = k;
      step(tb_gray(w), 1'b0);
    end
    repeat (4) step(tb_gray(w), 1'b0);
    check("fill_level", int'(bus.level), 3);
    check("fill_empty", int'(bus.empty), 0);

    // drain with rd_en held
    repeat (4) step(tb_gray(w), 1'b1);
    check("drain_rd_addr", int'(bus.rd_addr), 3);
    check("drain_empty",   int'(bus.empty),   1);
    check("drain_rd_gray", int'(bus.rd_gray), 2);

    // wrap: 20 more writes against a partially stalled reader
    written = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      ren = (cyc % 3) != 2;
      if (written < 20 && ((w - m_rd) & MASK) < DEPTH) begin
        w = (w + 1) & MASK;
        written++;
      end
      step(tb_gray(w), ren);
      check("wrap_level_bound", int'(bus.level <= DEPTH), 1);
    end
    check("wrap_empty",   int'(bus.empty),   1);
    check("wrap_rd_addr", int'(bus.rd_addr), 7);

    // concurrent write arrival and read at level 1
    w = (w + 1) & MASK;
    repeat (4) step(tb_gray(w), 1'b0);
    w = (w + 1) & MASK;
    repeat (2) step(tb_gray(w), 1'b0);
    step(tb_gray(w), 1'b1);
    step(tb_gray(w), 1'b0);
    check("conc_level", int'(bus.level), 1);

    // reset in the middle of traffic
    w = (w + 1) & MASK;
    repeat (2) step(tb_gray(w), 1'b1);
    do_reset();

    // multi-bit jump on the Gray input
    repeat (6) step(3, 1'b0);
`ifdef SGRAY_CHECK_EN
    check("err_jump", int'(bus.err), 1);
`else
    check("err_jump", int'(bus.err), 0);
`endif
    do_reset();

    // overrun to level 9
    for (int k = 1; k <= 9; k++) step(tb_gray(k), 1'b0);
    repeat (4) step(tb_gray(9), 1'b0);
    check("overrun_level", int'(bus.level), 9);
`ifdef SGRAY_CHECK_EN
    check("err_overrun", int'(bus.err), 1);
`else
    check("err_overrun", int'(bus.err), 0);
`endif
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
